psum_accum_relu: RTL and testbench

- Output stage directly downstream of the OFIFO in the corelet.
- Consumes one 8-lane psum row per beat from the OFIFO.
- Accumulates rows across all 9 kernel positions (kij) of a 3x3 convolution over a 6x6 input tile into a 16-entry on-chip accumulator bank.
- After the last beat, applies ReLU and writes the 16 output rows to the output SRAM, then pulses done.

---
 rtl/psum_pkg.sv | 49 ++++
 rtl/sat_add_lane.sv | 27 ++
 rtl/psum_accum_relu.sv | 164 ++++++++++++++++
 tb/tb_psum_accum_relu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared sizes, state encoding and kernel-window mapping for the psum accumulate/ReLU output stage.
package psum_pkg;

  localparam int COL           = 8;
  localparam int PSUM_BW       = 16;
  localparam int IN_DIM        = 6;
  localparam int K_DIM         = 3;
  localparam int OUT_DIM       = IN_DIM - K_DIM + 1;
  localparam int BEATS_PER_KIJ = IN_DIM * IN_DIM;
  localparam int NUM_KIJ       = K_DIM * K_DIM;
  localparam int NUM_OUT       = OUT_DIM * OUT_DIM;
  localparam int ROW_W         = COL * PSUM_BW;

  localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] o;
  } win_t;

  // Input pixel (ai,aj) under kernel tap (ki,kj) lands on output (ai-ki, aj-kj) if inside the 4x4 tile.
  function automatic win_t window_map(input logic [5:0] beat, input logic [3:0] kij);
    int   ai;
    int   aj;
    int   ki;
    int   kj;
    int   di;
    int   dj;
    win_t w;
    ai    = int'(beat) / IN_DIM;
    aj    = int'(beat) % IN_DIM;
    ki    = int'(kij) / K_DIM;
    kj    = int'(kij) % K_DIM;
    di    = ai - ki;
    dj    = aj - kj;
    w.hit = (di >= 0) && (di < OUT_DIM) && (dj >= 0) && (dj < OUT_DIM);
    w.o   = w.hit ? 4'(di * OUT_DIM + dj) : 4'd0;
    return w;
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One lane of signed psum accumulation: adds with one guard bit and clamps to the psum range.
module sat_add_lane
  import psum_pkg::*;
(
  input  logic signed [PSUM_BW-1:0] a_i,
  input  logic signed [PSUM_BW-1:0] b_i,
  output logic signed [PSUM_BW-1:0] sum_o,
  output logic                      ovf_o
);

  logic signed [PSUM_BW:0] wide;

  assign wide = {a_i[PSUM_BW-1], a_i} + {b_i[PSUM_BW-1], b_i};

  // Guard bit disagreeing with the sign bit means the true sum left the 16-bit range.
  always_comb begin
    ovf_o = (wide[PSUM_BW] != wide[PSUM_BW-1]);
    if (!ovf_o) begin
      sum_o = wide[PSUM_BW-1:0];
    end else if (wide[PSUM_BW]) begin
      sum_o = PSUM_MIN;
    end else begin
      sum_o = PSUM_MAX;
    end
  end

endmodule

// File: rtl/psum_accum_relu.sv
// OFIFO-side output stage: accumulates 9 kernel passes of psum rows into a 16-entry bank,
// then streams ReLU'd rows into the output SRAM and pulses done.
module psum_accum_relu
  import psum_pkg::*;
#(
  parameter int OP_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [ROW_W-1:0] in_data,
  output logic             in_rd,
  output logic [8:0]       OP_addr,
  output logic [ROW_W-1:0] OP_d,
  output logic             OP_cen,
  output logic             OP_wen,
  output logic             busy,
  output logic             done,
  output logic             sat_flag
);

  state_e           state_q, state_d;
  logic [5:0]       beat_q, beat_d;
  logic [3:0]       kij_q, kij_d;
  logic [3:0]       drain_q, drain_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;
  logic             consume;

  logic [ROW_W-1:0] acc_q [NUM_OUT];

  win_t             win;
  logic [ROW_W-1:0] acc_row;
  logic [ROW_W-1:0] sum_row;
  logic [COL-1:0]   lane_ovf;
  logic [ROW_W-1:0] drain_src;
  logic [ROW_W-1:0] drain_row;

  assign win       = window_map(beat_q, kij_q);
  assign acc_row   = acc_q[win.o];
  assign drain_src = acc_q[drain_q];

  genvar gi;
  generate
    for (gi = 0; gi < COL; gi++) begin : g_lane
      sat_add_lane u_add (
        .a_i   (acc_row[gi*PSUM_BW +: PSUM_BW]),
        .b_i   (in_data[gi*PSUM_BW +: PSUM_BW]),
        .sum_o (sum_row[gi*PSUM_BW +: PSUM_BW]),
        .ovf_o (lane_ovf[gi])
      );

      assign drain_row[gi*PSUM_BW +: PSUM_BW] =
        drain_src[gi*PSUM_BW + PSUM_BW - 1] ? '0 : drain_src[gi*PSUM_BW +: PSUM_BW];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    kij_d   = kij_q;
    drain_d = drain_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    consume = 1'b0;
    in_rd   = 1'b0;
    OP_cen  = 1'b1;
    OP_wen  = 1'b1;
    OP_addr = 9'd0;
    OP_d    = '0;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          sat_d   = 1'b0;
        end
      end

      CLEAR: begin
        beat_d  = 6'd0;
        kij_d   = 4'd0;
        state_d = ACCUM;
      end

      ACCUM: begin
        in_rd = in_valid;
        if (in_valid) begin
          consume = 1'b1;
          // Out-of-window beats still produce adder overflow; only real updates count.
          if (win.hit && (|lane_ovf)) begin
            sat_d = 1'b1;
          end
          if (beat_q == 6'(BEATS_PER_KIJ - 1)) begin
            beat_d = 6'd0;
            if (kij_q == 4'(NUM_KIJ - 1)) begin
              kij_d   = 4'd0;
              drain_d = 4'd0;
              state_d = DRAIN;
            end else begin
              kij_d = kij_q + 4'd1;
            end
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end

      DRAIN: begin
        OP_cen  = 1'b0;
        OP_wen  = 1'b0;
        OP_addr = 9'(OP_BASE) + {5'd0, drain_q};
        OP_d    = drain_row;
        if (drain_q == 4'(NUM_OUT - 1)) begin
          drain_d = 4'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= 6'd0;
      kij_q   <= 4'd0;
      drain_q <= 4'd0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      kij_q   <= kij_d;
      drain_q <= drain_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        acc_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        acc_q[i] <= '0;
      end
    end else if (consume && win.hit) begin
      acc_q[win.o] <= sum_row;
    end
  end

  assign done     = done_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_psum_accum_relu.sv
// Scoreboard bench for psum_accum_relu: expected output words are queued from a direct
// convolution model when a run is launched and popped as the block drains them.
module tb_psum_accum_relu;

  typedef struct packed {
    logic [8:0]   addr;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_rd;
  logic [8:0]   OP_addr;
  logic [127:0] OP_d;
  logic         OP_cen;
  logic         OP_wen;
  logic         busy;
  logic         done;
  logic         sat_flag;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  psum_accum_relu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .OP_addr  (OP_addr),
    .OP_d     (OP_d),
    .OP_cen   (OP_cen),
    .OP_wen   (OP_wen),
    .busy     (busy),
    .done     (done),
    .sat_flag (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row content for pass kij, beat a under each stimulus mode.
  function automatic logic [127:0] row(input int mode, input int kij, input int a);
    logic [127:0] r;
    r = '0;
    case (mode)
      0: for (int ln = 0; ln < 8; ln++) r[16*ln +: 16] = 16'd1;
      1: if (kij == 4 && a == 7) r[15:0] = 16'd5;
      2: begin
        r[63:48] = 16'hFFFE;
        r[79:64] = 16'd3;
      end
      default: r[15:0] = 16'd16000;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    logic [143:0] obs;
    logic [143:0] req;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    obs = {in_rd, OP_addr, OP_d, OP_cen, OP_wen, busy, done, sat_flag};
    req = {1'b0, 9'd0, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL reset_values got %h want %h", obs, req);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_conv(input string name, input int mode, input bit stall, input bit extra_start);
    exp_t         e;
    logic [127:0] w;
    logic [127:0] r;
    bit           exp_sat;
    int           acc;
    int           idx;
    int           cyc;
    int           stall_left;
    int           seen;
    bit           consumed;
    bit           x_done;

    exp_sat = 1'b0;
    for (int o = 0; o < 16; o++) begin
      w = '0;
      for (int ln = 0; ln < 8; ln++) begin
        acc = 0;
        for (int k = 0; k < 9; k++) begin
          r   = row(mode, k, ((o / 4) + k / 3) * 6 + (o % 4) + k % 3);
          acc = acc + int'($signed(r[16*ln +: 16]));
          if (acc > 32767) begin
            acc     = 32767;
            exp_sat = 1'b1;
          end else if (acc < -32768) begin
            acc     = -32768;
            exp_sat = 1'b1;
          end
        end
        if (acc < 0) acc = 0;
        w[16*ln +: 16] = 16'(acc);
      end
      e.addr = 9'(o);
      e.data = w;
      sb_q.push_back(e);
    end

    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (sat_flag !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_clear sat_flag=%b busy=%b want 0/1", name, sat_flag, busy);
    end

    idx        = 0;
    cyc        = 0;
    stall_left = 0;
    x_done     = 1'b0;
    while (idx < 324 && cyc < 3000) begin
      start = 1'b0;
      if (extra_start && !x_done && idx == 100) begin
        start  = 1'b1;
        x_done = 1'b1;
      end
      if (stall && stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 5);
      in_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_data = row(mode, idx / 36, idx % 36);
      #3;
      if (!in_valid) begin
        checks++;
        if (in_rd !== 1'b0) begin
          errors++;
          $display("FAIL %s in_rd_without_valid at beat %0d got %b want 0", name, idx, in_rd);
        end
      end
      consumed = (in_rd === 1'b1);
      @(negedge clk);
      if (consumed) idx++;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (idx < 324) begin
      errors++;
      $display("FAIL %s accum_timeout consumed %0d want 324", name, idx);
    end

    in_valid = 1'b1;
    in_data  = {128{1'b1}};
    seen     = 0;
    cyc      = 0;
    while (seen < 16 && cyc < 40) begin
      #1;
      checks++;
      if (in_rd !== 1'b0) begin
        errors++;
        $display("FAIL %s drain_in_rd got %b want 0", name, in_rd);
      end
      if (OP_cen === 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_word addr %0d", name, OP_addr);
        end else begin
          e = sb_q.pop_front();
          if (OP_wen !== 1'b0 || OP_addr !== e.addr || OP_d !== e.data || done !== 1'b0) begin
            errors++;
            $display("FAIL %s word got addr %0d data %h wen %b done %b want addr %0d data %h wen 0 done 0",
                     name, OP_addr, OP_d, OP_wen, done, e.addr, e.data);
          end
        end
        seen++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (seen < 16) begin
      errors++;
      $display("FAIL %s drain_timeout words %0d want 16", name, seen);
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || OP_cen !== 1'b1 || OP_wen !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse done=%b busy=%b cen=%b wen=%b want 1/0/1/1", name, done, busy, OP_cen, OP_wen);
    end
    checks++;
    if (sat_flag !== exp_sat) begin
      errors++;
      $display("FAIL %s sat_flag got %b want %b", name, sat_flag, exp_sat);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s after_done done=%b pending=%0d want 0/0", name, done, sb_q.size());
    end
    sb_q.delete();
    $display("%s: run complete, %0d words drained", name, seen);
  endtask

  task automatic test_reset_mid();
    logic [143:0] obs;
    logic [143:0] req;
    int           idx;
    int           cyc;
    bit           consumed;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    cyc   = 0;
    while (idx < 50 && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = row(0, 0, idx);
      #3;
      consumed = (in_rd === 1'b1);
      @(negedge clk);
      if (consumed) idx++;
      cyc++;
    end
    reset = 1'b0;
    #1;
    obs = {in_rd, OP_addr, OP_d, OP_cen, OP_wen, busy, done, sat_flag};
    req = {1'b0, 9'd0, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL reset_mid_accum got %h want %h", obs, req);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    $display("reset_mid: asserted after %0d beats", idx);
    run_conv("reset_mid_rerun", 0, 1'b0, 1'b0);
  endtask

  task automatic test_unit_rows();
    run_conv("unit_rows", 0, 1'b0, 1'b0);
  endtask

  task automatic test_window();
    run_conv("window_map", 1, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    run_conv("relu_neg", 2, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    run_conv("saturation", 3, 1'b0, 1'b0);
    run_conv("sat_cleared", 0, 1'b0, 1'b0);
  endtask

  task automatic test_stalls();
    run_conv("stalls_start", 0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_unit_rows();
    test_window();
    test_relu();
    test_saturation();
    test_stalls();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
